// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/en_reg.sv
// WIDTH-bit register with load enable and synchronous active-low reset.
module en_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Storage: clear on reset, load when enabled, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= {WIDTH{1'b0}};
        end else if (en_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/seq_divider.sv
// Unsigned divider by repeated subtraction, one subtraction per clock,
// with valid/ready handshakes on operands and result.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] div_q;
    logic             accept_s;

    assign accept_s = (state_q == IDLE) && in_valid;

    en_reg #(
        .WIDTH (WIDTH)
    ) u_divisor_reg (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (accept_s),
        .d_i   (divisor),
        .q_o   (div_q)
    );

    // State and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath update; results hold unless explicitly changed.
    always_comb begin
        state_d = state_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d = dividend;
                    if (divisor == {WIDTH{1'b0}}) begin
                        dbz_d   = 1'b1;
                        quot_d  = {WIDTH{1'b1}};
                        state_d = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        quot_d  = {WIDTH{1'b0}};
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // The compare guarantees the subtraction cannot underflow.
                if (rem_q >= div_q) begin
                    rem_d  = rem_q - div_q;
                    quot_d = quot_q + {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic model.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_quot"}, quotient, 0);
        check_eq({tag, "_rem"}, remainder, 0);
        check_eq({tag, "_dbz"}, div_by_zero, 0);
        check_eq({tag, "_ovalid"}, out_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_iready"}, in_ready, 1);
    endtask

    // One full operation: accept, wait for result, optional backpressure, handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int bp);
        logic [W-1:0] exp_q, exp_r;
        logic         exp_z;
        int           exp_lat;
        int           n;
        if (b == 0) begin
            exp_q = {W{1'b1}};
            exp_r = a;
            exp_z = 1'b1;
            exp_lat = 1;
        end else begin
            exp_q = a / b;
            exp_r = a % b;
            exp_z = 1'b0;
            exp_lat = int'(a / b) + 2;
        end
        @(negedge clk);
        check_eq("iready_before", in_ready, 1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = 1'b0;
        @(negedge clk);
        n = 1;
        while (!out_valid && n < 400) begin
            in_valid = 1'($urandom);
            dividend = W'($urandom);
            divisor  = W'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check_eq("latency", n, exp_lat);
        check_eq("quot", quotient, exp_q);
        check_eq("rem", remainder, exp_r);
        check_eq("dbz", div_by_zero, exp_z);
        check_eq("busy_done", busy, 1);
        check_eq("iready_done", in_ready, 0);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom);
            dividend = W'($urandom);
            divisor  = W'($urandom);
            @(negedge clk);
            check_eq("bp_ovalid", out_valid, 1);
            check_eq("bp_iready", in_ready, 0);
            check_eq("bp_quot", quotient, exp_q);
            check_eq("bp_rem", remainder, exp_r);
            check_eq("bp_dbz", div_by_zero, exp_z);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_ovalid", out_valid, 0);
        check_eq("post_iready", in_ready, 1);
        check_eq("post_busy", busy, 0);
        check_eq("post_quot", quotient, exp_q);
        check_eq("post_rem", remainder, exp_r);
    endtask

    initial begin
        int stray;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;

        do_op(8'd100, 8'd7, 0);
        do_op(8'd5, 8'd9, 0);
        do_op(8'd255, 8'd1, 0);
        do_op(8'd42, 8'd0, 0);
        do_op(8'd9, 8'd3, 0);
        do_op(8'd60, 8'd6, 5);

        // Reset during RUN discards the operation without an out_valid pulse.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("mid_busy", busy, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_reset_vals("midreset");
        stray = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check_eq("midreset_no_ovalid", stray, 0);
        do_op(8'd20, 8'd4, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : W'($urandom_range(1, 255));
            do_op(a, b, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Unsigned iterative divider that inverts the team's repeated-addition multiplier. It computes quotient and remainder by repeated subtraction, one subtraction per clock. It sits beside the multiplier in the arithmetic datapath. It uses a valid/ready handshake on both input and output, so a controller can issue one division at a time and absorb backpressure.

Parameters:
WIDTH, 8, bit width of dividend, divisor, quotient and remainder

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset (reset==0 at a rising edge resets the block)
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands (high only in IDLE)
dividend  input  WIDTH  unsigned dividend, sampled on accept
divisor  input  WIDTH  unsigned divisor, sampled on accept
out_valid  output  1  result available (high only in DONE)
out_ready  input  1  consumer takes result
quotient  output  WIDTH  unsigned quotient
remainder  output  WIDTH  unsigned remainder
div_by_zero  output  1  result flag: divisor was 0
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is synchronous and active-low, so it acts only on a rising clk edge where reset==0. It is named exactly as the multiplier names it.
- Reset values: state=IDLE, quotient=0, remainder=0, div_by_zero=0, out_valid=0, busy=0, in_ready=1.
- States: IDLE, RUN, DONE. Encoding comes from the package enum.
- Accept: happens at an edge where state==IDLE and in_valid==1; call this edge k.
  - Latch divisor into the divisor register.
  - remainder<=dividend, quotient<=0.
  - If divisor==0: div_by_zero<=1, quotient<=all-ones, remainder<=dividend, state<=DONE (out_valid visible after edge k+1... i.e. from the cycle after edge k).
  - Otherwise: div_by_zero<=0, state<=RUN.
- RUN, each edge:
  - If remainder>=divisor: remainder<=remainder-divisor, quotient<=quotient+1, stay in RUN.
  - Else: state<=DONE; quotient and remainder hold.
- Latency: for non-zero divisor with true quotient Q, RUN lasts Q+1 cycles and out_valid is first high after edge k+Q+2. For a zero divisor, out_valid is high after edge k+1.
- Arithmetic: quotient cannot exceed 2^WIDTH-1 because divisor>=1, so no wrap and no guard counter is needed. Subtraction is WIDTH bits and never underflows because of the compare.
- DONE: out_valid=1. quotient, remainder and div_by_zero are stable while out_ready==0 (backpressure of any length). At an edge with out_ready==1, state<=IDLE.
- After handshake: the result registers hold their last values until the next accept.
- in_ready: equals (state==IDLE). in_valid while busy is ignored, and operands are not sampled.
- Simultaneous events: out handshake and a new in_valid in the same cycle are not merged. The new operation is accepted no earlier than the following cycle, when the block is in IDLE. Zero-bubble back-to-back operation is not supported.
- Reset mid-operation: reset==0 at any edge in any state forces all reset values. Any in-flight result is discarded with no out_valid pulse.
- Input stability: dividend and divisor may change freely after the accept edge.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] div_state_t {IDLE, RUN, DONE};
  - localparam DIV_WIDTH_DEFAULT=8.
- One sub-module, en_reg: a WIDTH-bit register with enable and synchronous active-low reset.
  - Instantiated to hold the latched divisor, with enable = accept.
  - The remainder/quotient working registers and the FSM live in seq_divider.

Test Plan:
1. Reset low 2 cycles, then release; send dividend=100, divisor=7 -> quotient=14, remainder=2, div_by_zero=0; out_valid first high 16 edges after accept.
2. dividend=5, divisor=9 -> quotient=0, remainder=5; out_valid after 2 edges; out_ready held high completes the handshake in 1 cycle.
3. dividend=255, divisor=1 -> quotient=255, remainder=0; latency 257 edges; no wrap of quotient.
4. dividend=42, divisor=0 -> div_by_zero=1, quotient=255, remainder=42, out_valid after 1 edge; the next op 9/3 gives quotient=3, remainder=0, div_by_zero=0.
5. Backpressure: 60/6 with out_ready low for 5 cycles in DONE -> quotient=10, remainder=0 stable; in_ready=0; in_valid pulses with other operands ignored; IDLE the cycle after out_ready=1.
6. Reset mid-op: start 200/3, assert reset low at the 3rd RUN cycle -> all outputs 0 and in_ready=1 next cycle, no out_valid; then 20/4 -> quotient=5, remainder=0.
